// File: rtl/dut_seq_pkg.sv
// dut_seq_pkg: shared types and constants for the DUT sequencing controller.
//   state_e     - 3-bit sequencer state encoding (also exported on O_state)
//   drv_t       - registered DUT drive pair {rst, din}
//   state_drv() - state-to-drive lookup
//   cnt_load()  - down-counter reload value for an N-cycle state
package dut_seq_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_RST    = 3'd2,
    ST_PH_HI0 = 3'd3,
    ST_PH_LO  = 3'd4,
    ST_PH_HI1 = 3'd5,
    ST_FIN    = 3'd6
  } state_e;

  typedef struct packed {
    logic rst;
    logic din;
  } drv_t;

  localparam drv_t DRV_IDLE = '{rst: 1'b0, din: 1'b1};
  localparam drv_t DRV_PRE  = '{rst: 1'b0, din: 1'b1};
  localparam drv_t DRV_RST  = '{rst: 1'b1, din: 1'b0};
  localparam drv_t DRV_HI   = '{rst: 1'b0, din: 1'b1};
  localparam drv_t DRV_LO   = '{rst: 1'b0, din: 1'b0};
  localparam drv_t DRV_FIN  = '{rst: 1'b0, din: 1'b1};

  function automatic drv_t state_drv(input state_e s);
    drv_t d;
    case (s)
      ST_IDLE:   d = DRV_IDLE;
      ST_PRE:    d = DRV_PRE;
      ST_RST:    d = DRV_RST;
      ST_PH_HI0: d = DRV_HI;
      ST_PH_LO:  d = DRV_LO;
      ST_PH_HI1: d = DRV_HI;
      ST_FIN:    d = DRV_FIN;
      default:   d = DRV_IDLE;
    endcase
    return d;
  endfunction

  // A zero-cycle request degenerates to a single cycle rather than wrapping.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/dut_seq_chk.sv
// dut_seq_chk: response checker for the sequencing controller.
// Delays the driven DUT input by CHK_LAT cycles and compares it with the DUT
// output during the three stimulus phases, ignoring the first CHK_LAT phase
// cycles after reset exit (the delay line still holds reset-time data).
//   clk_i, rst_ni - clock, async active-low reset
//   din_i         - registered data driven to the DUT
//   dut_out_i     - DUT data output
//   state_i       - current controller state
//   clr_i         - clears the error count (sequence start)
//   err_cnt_o     - saturating mismatch count
module dut_seq_chk
  import dut_seq_pkg::*;
#(
  parameter int unsigned CHK_LAT = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         din_i,
  input  logic         dut_out_i,
  input  state_e       state_i,
  input  logic         clr_i,
  output logic [15:0]  err_cnt_o
);

  // Zero latency is treated as one stage.
  localparam int unsigned LAT = (CHK_LAT == 0) ? 1 : CHK_LAT;

  logic [LAT-1:0] dly_q;
  logic [15:0]    skip_q, skip_d;
  logic [15:0]    err_q, err_d;
  logic           in_ph;
  logic           mismatch;

  assign in_ph    = (state_i == ST_PH_HI0) || (state_i == ST_PH_LO) ||
                    (state_i == ST_PH_HI1);
  assign mismatch = in_ph && (skip_q == '0) && (dut_out_i != dly_q[LAT-1]);

  always_comb begin
    skip_d = skip_q;
    if (state_i == ST_RST) begin
      skip_d = 16'(LAT);
    end else if (in_ph && (skip_q != '0)) begin
      skip_d = skip_q - 16'd1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (clr_i) begin
      err_d = '0;
    end else if (mismatch && (err_q != '1)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dly_q  <= '0;
      skip_q <= '0;
      err_q  <= '0;
    end else begin
      dly_q[0] <= din_i;
      for (int unsigned i = 1; i < LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
      skip_q <= skip_d;
      err_q  <= err_d;
    end
  end

  assign err_cnt_o = err_q;

endmodule

// File: rtl/dut_seq_ctrl.sv
// dut_seq_ctrl: reset/stimulus sequencer for a single-bit DUT.
// On I_start in IDLE it idles PRE_CYC cycles, holds DUT reset RST_CYC cycles,
// drives din 1/0/1 for PH_CYC cycles each, pulses O_done for one cycle in FIN
// and returns to IDLE. I_abort returns to IDLE from any busy state.
// Optional checker enabled by macro DUT_SEQ_CHK_EN; otherwise O_err_cnt is 0.
//   I_clk, I_rst_n - clock, async active-low reset
//   I_start        - start request (sampled in IDLE)
//   I_abort        - synchronous abort
//   I_dut_out      - DUT data output (checker only)
//   O_dut_rst      - active-high DUT reset
//   O_dut_din      - DUT data input
//   O_busy, O_done - status; O_state current state; O_err_cnt mismatches
module dut_seq_ctrl
  import dut_seq_pkg::*;
#(
  parameter int unsigned PRE_CYC = 20,
  parameter int unsigned RST_CYC = 200,
  parameter int unsigned PH_CYC  = 2000,
  parameter int unsigned CHK_LAT = 2
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_start,
  input  logic        I_abort,
  input  logic        I_dut_out,
  output logic        O_dut_rst,
  output logic        O_dut_din,
  output logic        O_busy,
  output logic        O_done,
  output logic [2:0]  O_state,
  output logic [15:0] O_err_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero;
  drv_t             drv_d;
  logic             rst_q, din_q, busy_q, done_q;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    // Default: count down while staying, hold at zero; transitions reload.
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    if ((state_q != ST_IDLE) && I_abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (I_start) begin
            state_d = ST_PRE;
            cnt_d   = cnt_load(PRE_CYC);
          end
        end
        ST_PRE: if (cnt_zero) begin
          state_d = ST_RST;
          cnt_d   = cnt_load(RST_CYC);
        end
        ST_RST: if (cnt_zero) begin
          state_d = ST_PH_HI0;
          cnt_d   = cnt_load(PH_CYC);
        end
        ST_PH_HI0: if (cnt_zero) begin
          state_d = ST_PH_LO;
          cnt_d   = cnt_load(PH_CYC);
        end
        ST_PH_LO: if (cnt_zero) begin
          state_d = ST_PH_HI1;
          cnt_d   = cnt_load(PH_CYC);
        end
        ST_PH_HI1: if (cnt_zero) begin
          state_d = ST_FIN;
          cnt_d   = '0;
        end
        ST_FIN: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they align with O_state.
  always_comb drv_d = state_drv(state_d);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rst_q   <= 1'b0;
      din_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= drv_d.rst;
      din_q   <= drv_d.din;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_FIN);
    end
  end

  assign O_dut_rst = rst_q;
  assign O_dut_din = din_q;
  assign O_busy    = busy_q;
  assign O_done    = done_q;
  assign O_state   = state_q;

`ifdef DUT_SEQ_CHK_EN
  logic chk_clr;
  assign chk_clr = (state_q == ST_IDLE) && (state_d == ST_PRE);

  dut_seq_chk #(
    .CHK_LAT (CHK_LAT)
  ) u_chk (
    .clk_i     (I_clk),
    .rst_ni    (I_rst_n),
    .din_i     (din_q),
    .dut_out_i (I_dut_out),
    .state_i   (state_q),
    .clr_i     (chk_clr),
    .err_cnt_o (O_err_cnt)
  );
`else
  logic unused_dut_out;
  assign unused_dut_out = I_dut_out;
  assign O_err_cnt      = '0;
`endif

endmodule

// File: tb/tb_dut_seq_ctrl.sv
// tb_dut_seq_ctrl: directed self-checking bench for dut_seq_ctrl (defaults).
// Cycle c after start is the cycle between the c-1'th and c'th rising edge
// following the edge that samples I_start; outputs are sampled on falling edges.
module tb_dut_seq_ctrl;

  logic        I_clk   = 1'b0;
  logic        I_rst_n = 1'b1;
  logic        I_start = 1'b0;
  logic        I_abort = 1'b0;
  logic        I_dut_out;
  logic        O_dut_rst, O_dut_din, O_busy, O_done;
  logic [2:0]  O_state;
  logic [15:0] O_err_cnt;

  int checks   = 0;
  int failures = 0;

  logic d1, d2;
  logic stuck = 1'b0;

  dut_seq_ctrl #(
    .PRE_CYC (20),
    .RST_CYC (200),
    .PH_CYC  (2000),
    .CHK_LAT (2)
  ) dut (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .I_start   (I_start),
    .I_abort   (I_abort),
    .I_dut_out (I_dut_out),
    .O_dut_rst (O_dut_rst),
    .O_dut_din (O_dut_din),
    .O_busy    (O_busy),
    .O_done    (O_done),
    .O_state   (O_state),
    .O_err_cnt (O_err_cnt)
  );

  always #5 I_clk = ~I_clk;

  // Ideal DUT: output equals its input delayed two cycles.
  always @(posedge I_clk) begin
    d1 <= O_dut_din;
    d2 <= d1;
  end
  assign I_dut_out = stuck ? 1'b1 : d2;

  // Expected state for the default-parameter sequence, hand-derived ranges.
  function automatic logic [2:0] exp_state(input int c);
    if (c >= 1    && c <= 20)   return 3'd1;
    if (c >= 21   && c <= 220)  return 3'd2;
    if (c >= 221  && c <= 2220) return 3'd3;
    if (c >= 2221 && c <= 4220) return 3'd4;
    if (c >= 4221 && c <= 6220) return 3'd5;
    if (c == 6221)              return 3'd6;
    return 3'd0;
  endfunction

  function automatic logic exp_din(input int c);
    if (c >= 21   && c <= 220)  return 1'b0;
    if (c >= 2221 && c <= 4220) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge I_clk);
    I_start = 1'b0;
    I_abort = 1'b0;
    I_rst_n = 1'b0;
    repeat (2) @(negedge I_clk);
    I_rst_n = 1'b1;
  endtask

  task automatic start_pulse();
    @(negedge I_clk);
    I_start = 1'b1;
    @(posedge I_clk);
    #1 I_start = 1'b0;
  endtask

  task automatic test_reset();
    #1 I_rst_n = 1'b0;
    #2;
    checks++; if (O_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", O_state); end
    checks++; if (O_dut_rst !== 1'b0) begin failures++; $display("FAIL reset_dut_rst got=%b exp=0", O_dut_rst); end
    checks++; if (O_dut_din !== 1'b1) begin failures++; $display("FAIL reset_dut_din got=%b exp=1", O_dut_din); end
    checks++; if (O_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", O_busy); end
    checks++; if (O_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", O_done); end
    checks++; if (O_err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", O_err_cnt); end
    repeat (3) @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (3) @(negedge I_clk);
    checks++; if (O_state !== 3'd0) begin failures++; $display("FAIL idle_hold_state got=%0d exp=0", O_state); end
  endtask

  task automatic test_full_sequence();
    int rst_first = -1;
    int rst_last  = -1;
    int rst_len   = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int st_bad    = 0;
    int din_bad   = 0;
    int busy_bad  = 0;
    do_reset();
    repeat (3) @(posedge I_clk);
    start_pulse();
    for (int c = 1; c <= 6230; c++) begin
      @(negedge I_clk);
      if (O_dut_rst === 1'b1) begin
        if (rst_first < 0) rst_first = c;
        rst_last = c;
        rst_len++;
      end
      if (O_done === 1'b1) begin done_cnt++; done_cyc = c; end
      if (O_state !== exp_state(c)) st_bad++;
      if (O_dut_din !== exp_din(c)) din_bad++;
      if (O_busy !== (exp_state(c) != 3'd0)) busy_bad++;
    end
    checks++; if (rst_first != 21) begin failures++; $display("FAIL seq_rst_first got=%0d exp=21", rst_first); end
    checks++; if (rst_last != 220) begin failures++; $display("FAIL seq_rst_last got=%0d exp=220", rst_last); end
    checks++; if (rst_len != 200) begin failures++; $display("FAIL seq_rst_len got=%0d exp=200", rst_len); end
    checks++; if (din_bad != 0) begin failures++; $display("FAIL seq_din_pattern bad_cycles=%0d exp=0", din_bad); end
    checks++; if (st_bad != 0) begin failures++; $display("FAIL seq_state_trace bad_cycles=%0d exp=0", st_bad); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL seq_busy bad_cycles=%0d exp=0", busy_bad); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL seq_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc != 6221) begin failures++; $display("FAIL seq_done_cycle got=%0d exp=6221", done_cyc); end
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    int st_bad   = 0;
    logic [2:0] st20;
    // Abort on the last PRE cycle must win over the expiry into RST.
    do_reset();
    start_pulse();
    for (int c = 1; c <= 20; c++) @(negedge I_clk);
    st20 = O_state;
    checks++; if (st20 !== 3'd1) begin failures++; $display("FAIL abort_pre_state got=%0d exp=1", st20); end
    I_abort = 1'b1;
    @(negedge I_clk);
    I_abort = 1'b0;
    checks++; if (O_state !== 3'd0) begin failures++; $display("FAIL abort_priority_state got=%0d exp=0", O_state); end
    checks++; if (O_dut_rst !== 1'b0) begin failures++; $display("FAIL abort_priority_rst got=%b exp=0", O_dut_rst); end
    // Abort 50 cycles into RST.
    start_pulse();
    for (int c = 1; c <= 71; c++) begin
      @(negedge I_clk);
      if (O_done === 1'b1) done_cnt++;
    end
    checks++; if (O_dut_rst !== 1'b1) begin failures++; $display("FAIL abort_in_rst_pre got=%b exp=1", O_dut_rst); end
    I_abort = 1'b1;
    @(negedge I_clk);
    I_abort = 1'b0;
    checks++; if (O_state !== 3'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", O_state); end
    checks++; if (O_dut_rst !== 1'b0) begin failures++; $display("FAIL abort_dut_rst got=%b exp=0", O_dut_rst); end
    checks++; if (O_dut_din !== 1'b1) begin failures++; $display("FAIL abort_dut_din got=%b exp=1", O_dut_din); end
    checks++; if (O_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", O_busy); end
    for (int c = 0; c < 20; c++) begin
      if (O_done === 1'b1) done_cnt++;
      if (O_state !== 3'd0) st_bad++;
      @(negedge I_clk);
    end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    checks++; if (st_bad != 0) begin failures++; $display("FAIL abort_stays_idle bad_cycles=%0d exp=0", st_bad); end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int done1 = -1;
    int done2 = -1;
    logic [2:0] st100, st6222, st6223;
    do_reset();
    @(negedge I_clk);
    I_start = 1'b1;
    @(posedge I_clk);
    for (int c = 1; c <= 12450; c++) begin
      @(negedge I_clk);
      if (O_done === 1'b1) begin
        done_cnt++;
        if (done1 < 0) done1 = c; else done2 = c;
      end
      if (c == 100)  st100  = O_state;
      if (c == 6222) st6222 = O_state;
      if (c == 6223) st6223 = O_state;
    end
    I_start = 1'b0;
    checks++; if (st100 !== 3'd2) begin failures++; $display("FAIL b2b_start_ignored got=%0d exp=2", st100); end
    checks++; if (st6222 !== 3'd0) begin failures++; $display("FAIL b2b_idle_gap got=%0d exp=0", st6222); end
    checks++; if (st6223 !== 3'd1) begin failures++; $display("FAIL b2b_restart got=%0d exp=1", st6223); end
    checks++; if (done_cnt != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    checks++; if (done1 != 6221) begin failures++; $display("FAIL b2b_done1_cycle got=%0d exp=6221", done1); end
    checks++; if (done2 != 12443) begin failures++; $display("FAIL b2b_done2_cycle got=%0d exp=12443", done2); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_reset();
    start_pulse();
    for (int c = 1; c <= 3000; c++) @(negedge I_clk);
    checks++; if (O_state !== 3'd4) begin failures++; $display("FAIL rstmid_in_ph_lo got=%0d exp=4", O_state); end
    #2 I_rst_n = 1'b0;
    #1;
    checks++; if (O_state !== 3'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", O_state); end
    checks++; if (O_dut_rst !== 1'b0) begin failures++; $display("FAIL rstmid_dut_rst got=%b exp=0", O_dut_rst); end
    checks++; if (O_dut_din !== 1'b1) begin failures++; $display("FAIL rstmid_dut_din got=%b exp=1", O_dut_din); end
    checks++; if (O_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", O_busy); end
    checks++; if (O_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", O_done); end
    repeat (3) @(posedge I_clk);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge I_clk);
      if (O_state !== 3'd0 || O_done !== 1'b0 || O_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_idle_after bad_cycles=%0d exp=0", bad); end
  endtask

`ifdef DUT_SEQ_CHK_EN
  task automatic test_chk_match();
    stuck = 1'b0;
    do_reset();
    start_pulse();
    for (int c = 1; c <= 6221; c++) @(negedge I_clk);
    checks++; if (O_done !== 1'b1) begin failures++; $display("FAIL chk_match_done got=%b exp=1", O_done); end
    checks++; if (O_err_cnt !== 16'd0) begin failures++; $display("FAIL chk_match_err got=%0d exp=0", O_err_cnt); end
  endtask

  task automatic test_chk_stuck();
    stuck = 1'b1;
    do_reset();
    start_pulse();
    for (int c = 1; c <= 6221; c++) @(negedge I_clk);
    checks++; if (O_done !== 1'b1) begin failures++; $display("FAIL chk_stuck_done got=%b exp=1", O_done); end
    checks++; if (O_err_cnt !== 16'd2000) begin failures++; $display("FAIL chk_stuck_err got=%0d exp=2000", O_err_cnt); end
    @(negedge I_clk);
    checks++; if (O_err_cnt !== 16'd2000) begin failures++; $display("FAIL chk_err_hold got=%0d exp=2000", O_err_cnt); end
    start_pulse();
    @(negedge I_clk);
    checks++; if (O_err_cnt !== 16'd0) begin failures++; $display("FAIL chk_err_clear got=%0d exp=0", O_err_cnt); end
    I_abort = 1'b1;
    @(negedge I_clk);
    I_abort = 1'b0;
    stuck = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_sequence();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef DUT_SEQ_CHK_EN
    test_chk_match();
    test_chk_stuck();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
